// File: rtl/jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_driver
// Purpose  : Accepts a target word, drives one cycle of per-bit J/K excitation
//            into a JK flip-flop bank, then checks the Q readback.
// Revision : 1.0 - initial release
// ============================================================================
module jk_bank_driver #(
    parameter int WIDTH      = 8,
    parameter int DC_POLICY  = 0,
    parameter int SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] mismatch,
    output logic [5:0]       chg_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    localparam logic [3:0] c_settle_init = 4'(SETTLE_CYC - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_settle_cnt;
    logic [WIDTH-1:0] r_tgt;
    logic [WIDTH-1:0] r_qs;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_mismatch;
    logic [5:0]       r_chg_cnt;

    logic             w_accept;
    logic [WIDTH-1:0] w_dc;
    logic [WIDTH-1:0] w_j_exc;
    logic [WIDTH-1:0] w_k_exc;

    function automatic logic [5:0] f_popcount(input logic [WIDTH-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    assign w_accept = (r_state == ST_IDLE) && tgt_valid;

    // Don't-care bits: all-zero gives set/reset/hold, all-one gives toggle form.
    assign w_dc    = {WIDTH{(DC_POLICY != 0)}};
    assign w_j_exc = (~q_fb & tgt_data) | (q_fb & w_dc);
    assign w_k_exc = (q_fb & ~tgt_data) | (~q_fb & w_dc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (tgt_valid) w_state_nxt = ST_DRIVE;
            ST_DRIVE:  w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (r_settle_cnt == 4'd0) w_state_nxt = ST_CHECK;
            ST_CHECK:  w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle_cnt <= '0;
            r_tgt        <= '0;
            r_qs         <= '0;
            r_j          <= '0;
            r_k          <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_mismatch   <= '0;
            r_chg_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_j    <= '0;
            r_k    <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_tgt     <= tgt_data;
                        r_qs      <= q_fb;
                        r_j       <= w_j_exc;
                        r_k       <= w_k_exc;
                        r_chg_cnt <= f_popcount(tgt_data ^ q_fb);
                    end
                end
                ST_DRIVE: begin
                    r_settle_cnt <= c_settle_init;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt != 4'd0) begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                ST_CHECK: begin
                    r_mismatch <= q_fb ^ r_tgt;
                    r_done     <= (q_fb == r_tgt);
                    r_err      <= (q_fb != r_tgt);
                end
                default: ;
            endcase
        end
    end

    assign tgt_ready = (r_state == ST_IDLE) && !rst;
    assign busy      = (r_state != ST_IDLE);
    assign j_out     = r_j;
    assign k_out     = r_k;
    assign done      = r_done;
    assign err       = r_err;
    assign mismatch  = r_mismatch;
    assign chg_cnt   = r_chg_cnt;

    logic [WIDTH-1:0] w_unused_qs;
    assign w_unused_qs = r_qs;

endmodule
`default_nettype wire
